// File: rtl/clk_gen_pkg.sv
// Shared types and rate helpers for the fractional clock-enable generator.
// Increments are computed for a 2^acc_w phase accumulator clocked at clk_hz.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    // round(hz * 2^acc_w / clk_hz); 64-bit intermediate covers ACC_W up to ~32 at MHz rates
    function automatic longint unsigned inc_for_hz(input longint unsigned hz,
                                                   input longint unsigned clk_hz,
                                                   input int acc_w);
        return ((hz << acc_w) + (clk_hz / 2)) / clk_hz;
    endfunction

    localparam logic [23:0] INC_4M    = 24'(inc_for_hz(64'd4_000_000,  64'd25_000_000, 24));
    localparam logic [23:0] INC_8M    = 24'(inc_for_hz(64'd8_000_000,  64'd25_000_000, 24));
    localparam logic [23:0] INC_16M   = 24'(inc_for_hz(64'd16_000_000, 64'd25_000_000, 24));
    localparam logic [23:0] INC_7_16M = 24'(inc_for_hz(64'd7_160_000,  64'd25_000_000, 24));

endpackage

// File: rtl/ce_nco_ch.sv
// One NCO channel: phase accumulator with a shadowed increment applied on carry.
// ce is registered, high the cycle after the accumulator wraps; config writes never stall.
module ce_nco_ch #(
    parameter int               ACC_W   = 24,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clk25,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic             i_enter,
    input  logic             i_sync,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [ACC_W-1:0] i_wr_inc,
    output logic             o_ce,
    output logic             o_busy
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_ce;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_step;
    logic             w_apply;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry = w_sum[ACC_W];
    assign w_step  = i_run & i_en & ~i_sync & ~i_clear;

    // Swapping on the wrap edge keeps phase continuous; an idle or stopped channel swaps at once.
    assign w_apply = r_pending & (i_sync | i_enter | (r_inc == '0) | ~i_en | (w_step & w_carry));

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_inc     <= INC_RST;
            r_shadow  <= INC_RST;
            r_pending <= 1'b0;
            r_ce      <= 1'b0;
        end else begin
            if (i_sync | i_clear) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else if (w_step) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_carry;
            end else begin
                r_ce  <= 1'b0;
            end

            if (w_apply) begin
                r_inc <= r_shadow;
            end

            if (i_wr) begin
                r_shadow  <= i_wr_inc;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_ce   = r_ce;
    assign o_busy = r_pending;

endmodule

// File: rtl/ce_frac_gen.sv
// Multi-channel fractional CE generator gated on PLL lock plus a settle delay.
// CE pulses are registered (one cycle after carry); config writes accepted every cycle.
module ce_frac_gen
    import clk_gen_pkg::*;
#(
    parameter int                     NCH         = 4,
    parameter int                     ACC_W       = 24,
    parameter int                     CLK_HZ      = 25_000_000,
    parameter int                     LOCK_SETTLE = 16,
    parameter logic [NCH*ACC_W-1:0]   INC_INIT    =
        {NCH{ACC_W'(inc_for_hz(64'd4_000_000, 64'(CLK_HZ), ACC_W))}},
    localparam int                    CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk25,
    input  logic             rst,
    input  logic             locked_i,
    input  logic             sync_i,
    input  logic [NCH-1:0]   ch_en,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic [NCH-1:0]   cfg_busy,
    output logic [NCH-1:0]   ce,
    output logic             running
);

    localparam int CW = $clog2(LOCK_SETTLE + 1);

    logic          r_lock_m;
    logic          r_lock_s;
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;

    logic          w_run;
    logic          w_clear;
    logic          w_enter;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= locked_i;
            r_lock_s <= r_lock_m;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_LOCK: if (r_lock_s) w_next = SETTLE;
            SETTLE: begin
                if (!r_lock_s) begin
                    w_next = WAIT_LOCK;
                end else if (r_cnt == CW'(LOCK_SETTLE - 1)) begin
                    w_next = RUN;
                end
            end
            RUN:       if (!r_lock_s) w_next = WAIT_LOCK;
            default:   w_next = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == SETTLE) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Accumulators only advance on edges that stay in RUN; the lock-loss edge zeroes them.
    assign w_run   = (r_state == RUN) & r_lock_s;
    assign w_clear = (r_state == RUN) & ~r_lock_s;
    assign w_enter = (r_state != RUN) & (w_next == RUN);
    assign running = (r_state == RUN);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic w_wr;
        assign w_wr = cfg_we & (cfg_ch == CHW'(g));

        ce_nco_ch #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_INIT[g*ACC_W +: ACC_W])
        ) u_ch (
            .clk25    (clk25),
            .rst      (rst),
            .i_run    (w_run),
            .i_clear  (w_clear),
            .i_enter  (w_enter),
            .i_sync   (sync_i),
            .i_en     (ch_en[g]),
            .i_wr     (w_wr),
            .i_wr_inc (cfg_inc),
            .o_ce     (ce[g]),
            .o_busy   (cfg_busy[g])
        );
    end

endmodule
